// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the IF->ID instruction queue: the canonical NOP
// encoding, default geometry and the per-cycle queue operation encoding.
package if_id_queue_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0) presented to ID when no entry is valid.
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  // Default geometry shared by the queue and its interface.
  localparam int unsigned DEF_XLEN       = 32;
  localparam int unsigned DEF_ILEN       = 32;
  localparam int unsigned DEF_DEPTH      = 4;
  localparam int unsigned DEF_INST_BYTES = 4;

  // What the queue does on a given edge, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } q_op_e;

endpackage

// File: rtl/if_id_queue_if.sv
// Handshake bundle between the fetch stage (master) and the IF/ID queue
// (slave). The queue's downstream side toward ID travels in the same bundle.
interface if_id_queue_if
  import if_id_queue_pkg::*;
#(
  parameter int unsigned XLEN  = DEF_XLEN,
  parameter int unsigned ILEN  = DEF_ILEN,
  parameter int unsigned DEPTH = DEF_DEPTH
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Redirect from a taken jump/branch.
  logic            flush_i;

  // Upstream side (IF -> queue).
  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] pc_i;
  logic [ILEN-1:0] instr_i;

  // Downstream side (queue -> ID).
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] pc_next_o;
  logic [ILEN-1:0] instr_o;

  // Occupancy, 0..DEPTH.
  logic [CW-1:0]   count_o;

  modport master (
    output flush_i,
    output in_valid_i,
    output pc_i,
    output instr_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  pc_o,
    input  pc_next_o,
    input  instr_o,
    input  count_o
  );

  modport slave (
    input  flush_i,
    input  in_valid_i,
    input  pc_i,
    input  instr_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output pc_o,
    output pc_next_o,
    output instr_o,
    output count_o
  );

endinterface

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: a small registered FIFO of {pc, pc_next, instr}
// between fetch and decode. Entries become visible the cycle after they are
// pushed, a full queue never accepts even while popping, and a flush empties
// the queue at the next edge. Outputs are masked to 0 / NOP while empty.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned XLEN       = DEF_XLEN,
  parameter int unsigned ILEN       = DEF_ILEN,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned INST_BYTES = DEF_INST_BYTES
) (
  input  logic          clk,
  input  logic          reset,
  if_id_queue_if.slave  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Entry storage: one flop row per slot, three fields per row.
  logic [XLEN-1:0] pc_mem      [DEPTH];
  logic [XLEN-1:0] pc_next_mem [DEPTH];
  logic [ILEN-1:0] instr_mem   [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  q_op_e           op;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Ready depends only on occupancy, so a pop in the same cycle never opens
  // a slot for a push into a full queue.
  assign push = bus.in_valid_i  && !full  && !bus.flush_i;
  assign pop  = bus.out_ready_i && !empty && !bus.flush_i;
  assign op   = q_op_e'({push, pop});

  // Occupancy and pointer update; reset wins over flush, flush over push/pop.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      case (op)
        OP_PUSH: begin
          wr_ptr <= wr_ptr + PW'(1);
          count  <= count + CW'(1);
        end
        OP_POP: begin
          rd_ptr <= rd_ptr + PW'(1);
          count  <= count - CW'(1);
        end
        OP_BOTH: begin
          wr_ptr <= wr_ptr + PW'(1);
          rd_ptr <= rd_ptr + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // Capture the offered entry; pc_next is formed here so the ID side sees a
  // plain register with no adder in its path.
  // NOTE: the storage array is deliberately left without reset; stale rows are
  // never observable because the outputs are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]      <= bus.pc_i;
      pc_next_mem[wr_ptr] <= bus.pc_i + XLEN'(INST_BYTES);
      instr_mem[wr_ptr]   <= bus.instr_i;
    end
  end

  // Present the head entry, or 0 / NOP when there is nothing to hand to ID.
  // NOTE: every output gets a default first so no path through the block can
  // leave one unassigned and infer a latch.
  always_comb begin
    bus.pc_o      = '0;
    bus.pc_next_o = '0;
    bus.instr_o   = ILEN'(INST_NOP);
    if (!empty) begin
      bus.pc_o      = pc_mem[rd_ptr];
      bus.pc_next_o = pc_next_mem[rd_ptr];
      bus.instr_o   = instr_mem[rd_ptr];
    end
  end

  assign bus.in_ready_o  = !full;
  assign bus.out_valid_o = !empty;
  assign bus.count_o     = count;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue. A driver issues one cycle of stimulus
// at a time and pushes every entry it expects the queue to accept into a
// scoreboard; a monitor on the falling edge compares the DUT outputs against
// the scoreboard head and pops it whenever ID consumes an entry.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int XLEN       = 32;
  localparam int ILEN       = 32;
  localparam int DEPTH      = 4;
  localparam int INST_BYTES = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  if_id_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus ();

  if_id_queue #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .INST_BYTES(INST_BYTES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] instr;
  } ent_t;

  ent_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare status and head against the scoreboard, consume on pop.
  always @(negedge clk) begin
    check("count",     64'(bus.count_o),     64'(exp_q.size()));
    check("in_ready",  64'(bus.in_ready_o),  64'(exp_q.size() < DEPTH));
    check("out_valid", 64'(bus.out_valid_o), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check("head_pc",      64'(bus.pc_o),      64'(exp_q[0].pc));
      check("head_pc_next", 64'(bus.pc_next_o), 64'(exp_q[0].pc_next));
      check("head_instr",   64'(bus.instr_o),   64'(exp_q[0].instr));
      if (bus.out_ready_i && !bus.flush_i && !reset) void'(exp_q.pop_front());
    end else begin
      check("idle_pc",      64'(bus.pc_o),      64'h0);
      check("idle_pc_next", 64'(bus.pc_next_o), 64'h0);
      check("idle_instr",   64'(bus.instr_o),   64'h0000_0013);
    end
  end

  // One cycle of stimulus; pcn is the hand-computed expected pc_next.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] pcn, input logic ordy);
    logic accept;
    @(posedge clk);
    #1;
    reset           = rst;
    bus.flush_i     = fl;
    bus.in_valid_i  = iv;
    bus.pc_i        = pc;
    bus.instr_i     = instr;
    bus.out_ready_i = ordy;
    accept = iv && !rst && !fl && (exp_q.size() < DEPTH);
    @(negedge clk);
    #1;
    if (rst || fl) exp_q.delete();
    else if (accept) exp_q.push_back('{pc, pcn, instr});
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr,
                      input logic [31:0] pcn, input logic ordy);
    step(1'b0, 1'b0, 1'b1, pc, instr, pcn, ordy);
  endtask

  task automatic nop(input logic ordy);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, ordy);
  endtask

  // Hard bound on simulation time.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.flush_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.pc_i        = '0;
    bus.instr_i     = '0;
    bus.out_ready_i = 1'b0;
    void'($urandom(32'd2024));

    // Reset.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Single push, visible one cycle later.
    push(32'h0000_0100, 32'h0050_0093, 32'h0000_0104, 1'b0);
    nop(1'b0);
    check("single_valid",   64'(bus.out_valid_o), 64'h1);
    check("single_pc",      64'(bus.pc_o),        64'h100);
    check("single_pc_next", 64'(bus.pc_next_o),   64'h104);
    check("single_instr",   64'(bus.instr_o),     64'h0050_0093);
    check("single_count",   64'(bus.count_o),     64'h1);

    // Fill to DEPTH, refuse a fifth offer, drain in order.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    push(32'h0000_0100, 32'h1111_0001, 32'h0000_0104, 1'b0);
    push(32'h0000_0104, 32'h1111_0002, 32'h0000_0108, 1'b0);
    push(32'h0000_0108, 32'h1111_0003, 32'h0000_010C, 1'b0);
    push(32'h0000_010C, 32'h1111_0004, 32'h0000_0110, 1'b0);
    push(32'h0000_0110, 32'h1111_0005, 32'h0000_0114, 1'b0);
    nop(1'b0);
    check("full_count",    64'(bus.count_o),    64'h4);
    check("full_in_ready", 64'(bus.in_ready_o), 64'h0);
    check("full_head_pc",  64'(bus.pc_o),       64'h100);
    nop(1'b1);
    nop(1'b1);
    nop(1'b1);
    nop(1'b1);
    nop(1'b0);
    check("drained_count", 64'(bus.count_o), 64'h0);

    // Full queue: simultaneous push and pop takes only the pop.
    push(32'h0000_0200, 32'h2222_0001, 32'h0000_0204, 1'b0);
    push(32'h0000_0204, 32'h2222_0002, 32'h0000_0208, 1'b0);
    push(32'h0000_0208, 32'h2222_0003, 32'h0000_020C, 1'b0);
    push(32'h0000_020C, 32'h2222_0004, 32'h0000_0210, 1'b0);
    push(32'h0000_0210, 32'h2222_0005, 32'h0000_0214, 1'b1);
    nop(1'b0);
    check("full_pushpop_count", 64'(bus.count_o), 64'h3);
    check("full_pushpop_head",  64'(bus.pc_o),    64'h204);

    // Flush with simultaneous push and pop at count 3.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h3333_0001, 32'h0000_0304, 1'b1);
    nop(1'b0);
    check("flush_count", 64'(bus.count_o),     64'h0);
    check("flush_valid", 64'(bus.out_valid_o), 64'h0);
    check("flush_instr", 64'(bus.instr_o),     64'h0000_0013);
    check("flush_pc",    64'(bus.pc_o),        64'h0);

    // Held flush keeps the queue empty; first push lands when it drops.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0310, 32'h3333_0002, 32'h0000_0314, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0314, 32'h3333_0003, 32'h0000_0318, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0318, 32'h3333_0004, 32'h0000_031C, 1'b0);
    push(32'h0000_0400, 32'h4444_0001, 32'h0000_0404, 1'b0);
    nop(1'b0);
    check("post_flush_count", 64'(bus.count_o), 64'h1);
    check("post_flush_pc",    64'(bus.pc_o),    64'h400);

    // Mid-occupancy push+pop keeps count and advances the head.
    push(32'h0000_0404, 32'h4444_0002, 32'h0000_0408, 1'b0);
    push(32'h0000_0408, 32'h4444_0003, 32'h0000_040C, 1'b1);
    nop(1'b0);
    check("mid_pushpop_count", 64'(bus.count_o), 64'h2);
    check("mid_pushpop_head",  64'(bus.pc_o),    64'h404);
    nop(1'b1);
    nop(1'b1);

    // pc_next wraps at 2^XLEN.
    push(32'hFFFF_FFFC, 32'h5555_0001, 32'h0000_0000, 1'b0);
    nop(1'b0);
    check("wrap_pc_next", 64'(bus.pc_next_o), 64'h0);
    nop(1'b1);

    // Pop on empty does nothing.
    nop(1'b1);
    nop(1'b0);
    check("empty_pop_count", 64'(bus.count_o), 64'h0);

    // Reset mid-operation beats push and pop.
    push(32'h0000_0600, 32'h6666_0001, 32'h0000_0604, 1'b0);
    push(32'h0000_0604, 32'h6666_0002, 32'h0000_0608, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0608, 32'h6666_0003, 32'h0000_060C, 1'b1);
    nop(1'b0);
    check("mid_reset_count", 64'(bus.count_o), 64'h0);

    // Random traffic with phases biased toward filling and draining.
    for (int c = 0; c < 10000; c++) begin
      logic        rr, ff, iv, ordy;
      logic [31:0] pc, ins;
      rr   = (c == 5000) || ($urandom_range(0, 499) == 0);
      ff   = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = (((c / 64) % 2) == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      pc   = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 31) == 0) pc = 32'hFFFF_FFFC;
      ins  = $urandom();
      step(rr, ff, iv, pc, ins, pc + 32'd4, ordy);
    end
    nop(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter XLEN, default 32, PC width in bits.
REQ-002 Parameter ILEN, default 32, instruction width in bits.
REQ-003 Parameter DEPTH, default 4, entry count; SHALL be a power of two, >=2.
REQ-004 Parameter INST_BYTES, default 4, PC increment used to form pc_next.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flush_i  input  1  pipeline redirect (jump/branch taken); discards all queued entries.
REQ-008 in_valid_i  input  1  IF offers an entry this cycle.
REQ-009 in_ready_o  output  1  queue accepts an entry this cycle.
REQ-010 pc_i  input  XLEN  PC of offered instruction.
REQ-011 instr_i  input  ILEN  offered instruction word.
REQ-012 out_valid_o  output  1  head entry valid toward ID.
REQ-013 out_ready_i  input  1  ID consumes head entry this cycle.
REQ-014 pc_o  output  XLEN  head PC.
REQ-015 pc_next_o  output  XLEN  head PC + INST_BYTES.
REQ-016 instr_o  output  ILEN  head instruction.
REQ-017 count_o  output  clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Function
REQ-018 Push occurs on a cycle with in_valid_i && in_ready_o && !flush_i; pop occurs on a cycle with out_valid_o && out_ready_i && !flush_i.
REQ-019 in_ready_o SHALL be high exactly when count_o < DEPTH; no bypass when full, even with simultaneous pop.
REQ-020 out_valid_o SHALL be high exactly when count_o > 0.
REQ-021 Latency: an entry pushed at edge N SHALL be visible on outputs after edge N (next cycle), never combinationally in the push cycle.
REQ-022 Entries SHALL leave in push order (FIFO); pointers wrap modulo DEPTH.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-024 pc_next_o SHALL equal pc_o + INST_BYTES truncated to XLEN bits (wraps at 2^XLEN); computed at push time and stored.
REQ-025 When out_valid_o is low, pc_o and pc_next_o SHALL be 0 and instr_o SHALL be INST_NOP (32'h00000013 zero-extended/truncated to ILEN).
REQ-026 flush_i high SHALL, at the next edge, set count to 0 and both pointers to 0; a same-cycle push or pop is discarded.
REQ-027 flush_i held high for multiple cycles SHALL keep the queue empty; the first push is accepted on the cycle flush_i deasserts.
REQ-028 out_valid_o/out_ready_i handshake: head entry and its outputs SHALL stay stable while out_valid_o && !out_ready_i && !flush_i.
REQ-029 Pop attempted when empty and push attempted when full SHALL have no effect on state.

Reset
REQ-030 reset SHALL, at the next edge, clear count, read and write pointers; outputs become out_valid_o=0, in_ready_o=1, count_o=0, pc_o=0, pc_next_o=0, instr_o=INST_NOP.
REQ-031 reset SHALL take priority over flush_i, push and pop; reset mid-operation discards all entries.
REQ-032 Storage array contents SHALL NOT require reset; outputs are masked per REQ-025.

Structure
REQ-033 INST_NOP SHALL come from the shared defines file; no local redefinition.
REQ-034 No sub-module; storage array, pointers and counter live in if_id_queue.
REQ-035 Storage SHALL be registered (flip-flop array, DEPTH x (XLEN+XLEN+ILEN)).

Verification
REQ-036 Reset, then push pc=0x100/instr=0x00500093 -> next cycle out_valid_o=1, pc_o=0x100, pc_next_o=0x104, instr_o=0x00500093, count_o=1.
REQ-037 Push 4 entries with out_ready_i=0 (DEPTH=4) -> count_o=4, in_ready_o=0; 5th offer not accepted; then pop all -> order 0x100,0x104,0x108,0x10C.
REQ-038 Full queue, push and pop same cycle -> pop taken, push refused, count_o=3 next cycle.
REQ-039 Queue count 3, flush_i=1 with simultaneous push -> next cycle count_o=0, out_valid_o=0, instr_o=0x00000013, pc_o=0.
REQ-040 Push pc=0xFFFFFFFC -> pc_next_o=0x00000000.
REQ-041 Random push/pop/flush for 10000 cycles with reset asserted mid-run, checked against a reference queue model -> zero mismatches; pointer wrap exercised.
